// File: rtl/rrat_freelist_pkg.sv
// Shared rename parameters for the retirement map and its physical-tag free list.
package rv32i_types;

    localparam int PHYS_REG_BITS = 6;
    localparam int ARCH_REG_BITS = 5;
    localparam int NUM_PHYS_REGS = 64;
    localparam int FL_DEPTH      = 32;

endpackage

// File: rtl/rrat_freelist_free_list.sv
// Circular FIFO of free physical tags. Flush reclaims every slot, because the
// slots between tail and head still hold the speculatively allocated tags.
module free_list
    import rv32i_types::*;
#(
    parameter int DATA_BITS = PHYS_REG_BITS,
    parameter int DEPTH     = FL_DEPTH,
    parameter int INIT_BASE = NUM_PHYS_REGS - FL_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] pop_data,
    output logic                 empty,
    output logic                 full,
    input  logic                 flush
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [PW-1:0]        head_r;
    logic [PW-1:0]        tail_r;
    logic [PW-1:0]        tail_nxt_s;
    logic [CW-1:0]        count_r;
    logic                 pop_ok_s;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Status flags, head data and the post-push tail used by flush.
    always_comb begin
        empty      = (count_r == {CW{1'b0}});
        full       = (count_r == CW'(DEPTH));
        pop_data   = mem_r[head_r];
        pop_ok_s   = pop && !empty;
        tail_nxt_s = push ? ptr_inc(tail_r) : tail_r;
    end

    // Slot storage: reset to the upper tag range, write the freed tag at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_r[j] <= DATA_BITS'(INIT_BASE + j);
            end
        end else if (push) begin
            mem_r[tail_r] <= push_data;
        end
    end

    // Head/tail/count; a flush rewinds head to the post-push tail and refills.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= CW'(DEPTH);
        end else begin
            tail_r <= tail_nxt_s;
            if (flush) begin
                head_r  <= tail_nxt_s;
                count_r <= CW'(DEPTH);
            end else begin
                if (pop_ok_s) begin
                    head_r <= ptr_inc(head_r);
                end
                count_r <= count_r + CW'(push) - CW'(pop_ok_s);
            end
        end
    end

endmodule

// File: rtl/rrat_freelist.sv
// Retirement RAT plus free list: commits retire a mapping and recycle the
// previous physical tag; dispatch pops new tags; a flush reclaims in-flight tags.
module rrat_freelist_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic flush,
    input logic full
);

    // A tag pushed into a full list with no accepted pop would be lost.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !(pop && !flush)));

endmodule

module rrat_freelist #(
    parameter int PHYS_REG_BITS = rv32i_types::PHYS_REG_BITS,
    parameter int ARCH_REG_BITS = rv32i_types::ARCH_REG_BITS,
    parameter int FL_DEPTH      = rv32i_types::FL_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    output logic [PHYS_REG_BITS-1:0] pd_alloc,
    output logic                     fl_empty,
    input  logic                     commit_we,
    input  logic [ARCH_REG_BITS-1:0] commit_rd,
    input  logic [PHYS_REG_BITS-1:0] commit_pd,
    input  logic                     global_branch_signal,
    output logic [PHYS_REG_BITS-1:0] rrat [2**ARCH_REG_BITS]
);

    logic                     commit_v_s;
    logic [PHYS_REG_BITS-1:0] old_pd_s;
    logic                     fl_full_s;

    // x0 never renames, so commits to it leave both map and list untouched.
    always_comb begin
        commit_v_s = commit_we && (commit_rd != {ARCH_REG_BITS{1'b0}});
        old_pd_s   = rrat[commit_rd];
    end

    // Retirement map: identity at reset, committed mapping otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ARCH_REG_BITS; i++) begin
                rrat[i] <= PHYS_REG_BITS'(i);
            end
        end else if (commit_v_s) begin
            rrat[commit_rd] <= commit_pd;
        end
    end

    free_list #(
        .DATA_BITS (PHYS_REG_BITS),
        .DEPTH     (FL_DEPTH),
        .INIT_BASE (rv32i_types::NUM_PHYS_REGS - FL_DEPTH)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .push      (commit_v_s),
        .push_data (old_pd_s),
        .pop       (alloc_req),
        .pop_data  (pd_alloc),
        .empty     (fl_empty),
        .full      (fl_full_s),
        .flush     (global_branch_signal)
    );

    rrat_freelist_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (commit_v_s),
        .pop   (alloc_req),
        .flush (global_branch_signal),
        .full  (fl_full_s)
    );

endmodule

// File: tb/tb_rrat_freelist.sv
// Self-checking bench: a tag-level reference model (free queue + in-flight
// queue in allocation order + map) feeds a scoreboard of expected outputs.
module tb_rrat_freelist;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_req = 1'b0;
    logic       commit_we = 1'b0;
    logic [4:0] commit_rd = 5'd0;
    logic [5:0] commit_pd = 6'd0;
    logic       global_branch_signal = 1'b0;
    logic [5:0] pd_alloc;
    logic       fl_empty;
    logic [5:0] rrat [32];

    typedef struct packed {
        logic [5:0]   pd;
        logic         empty;
        logic [191:0] map;
    } exp_t;

    exp_t       sb_q [$];
    logic [5:0] free_q [$];
    logic [5:0] infl_q [$];
    logic [5:0] m_rrat [32];
    int         n_chk = 0;
    int         n_fail = 0;

    rrat_freelist dut (
        .clk                  (clk),
        .rst                  (rst),
        .alloc_req            (alloc_req),
        .pd_alloc             (pd_alloc),
        .fl_empty             (fl_empty),
        .commit_we            (commit_we),
        .commit_rd            (commit_rd),
        .commit_pd            (commit_pd),
        .global_branch_signal (global_branch_signal),
        .rrat                 (rrat)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        free_q = {};
        infl_q = {};
        for (int i = 0; i < 32; i++) begin
            m_rrat[i] = 6'(i);
            free_q.push_back(6'(32 + i));
        end
    endtask

    // Drive one cycle, advance the model, queue the expected outputs.
    task automatic drive(input logic r, input logic a, input logic we,
                         input logic [4:0] rd, input logic fl);
        exp_t       e;
        int         pre_sz;
        logic [5:0] t;
        logic [5:0] pd;
        @(negedge clk);
        pd = (infl_q.size() > 0) ? infl_q[0] : 6'(40);
        rst = r; alloc_req = a; commit_we = we; commit_rd = rd;
        commit_pd = pd; global_branch_signal = fl;
        if (r) begin
            model_reset();
        end else begin
            pre_sz = free_q.size();
            if (we && rd != 5'd0 && infl_q.size() > 0) begin
                t = infl_q.pop_front();
                free_q.push_back(m_rrat[rd]);
                m_rrat[rd] = t;
            end
            if (fl) begin
                free_q = {infl_q, free_q};
                infl_q = {};
            end else if (a && pre_sz > 0) begin
                infl_q.push_back(free_q.pop_front());
            end
        end
        e.empty = (free_q.size() == 0);
        e.pd    = (free_q.size() > 0) ? free_q[0] : infl_q[0];
        for (int i = 0; i < 32; i++) e.map[i*6 +: 6] = m_rrat[i];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
        e = sb_q.pop_front();
        n_chk += 4;
        if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL reset_pd: got %0d expected %0d", pd_alloc, e.pd); end
        if (pd_alloc !== 6'd32) begin n_fail++; $display("FAIL reset_pd32: got %0d expected 32", pd_alloc); end
        if (fl_empty !== e.empty) begin n_fail++; $display("FAIL reset_empty: got %0b expected %0b", fl_empty, e.empty); end
        if (fl_empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty0: got %0b expected 0", fl_empty); end
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if (rrat[i] !== e.map[i*6 +: 6]) begin n_fail++; $display("FAIL reset_rrat[%0d]: got %0d expected %0d", i, rrat[i], e.map[i*6 +: 6]); end
        end
    endtask

    task automatic test_pop3();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            e = sb_q.pop_front();
            n_chk += 2;
            if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL pop3_pd: got %0d expected %0d", pd_alloc, e.pd); end
            if (fl_empty !== e.empty) begin n_fail++; $display("FAIL pop3_empty: got %0b expected %0b", fl_empty, e.empty); end
        end
    endtask

    task automatic test_exhaust();
        exp_t       e;
        int         popped = 0;
        logic [5:0] held;
        while (fl_empty !== 1'b1 && popped < 40) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            popped++;
            e = sb_q.pop_front();
            n_chk += 2;
            if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL exhaust_pd: got %0d expected %0d", pd_alloc, e.pd); end
            if (fl_empty !== e.empty) begin n_fail++; $display("FAIL exhaust_empty: got %0b expected %0b", fl_empty, e.empty); end
        end
        n_chk++;
        if (popped != 29) begin n_fail++; $display("FAIL exhaust_count: got %0d pops expected 29", popped); end
        held = pd_alloc;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            e = sb_q.pop_front();
            n_chk += 3;
            if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL empty_pop_pd: got %0d expected %0d", pd_alloc, e.pd); end
            if (pd_alloc !== held) begin n_fail++; $display("FAIL empty_pop_hold: got %0d expected %0d", pd_alloc, held); end
            if (fl_empty !== 1'b1) begin n_fail++; $display("FAIL empty_pop_flag: got %0b expected 1", fl_empty); end
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        e = sb_q.pop_front();
        n_chk += 2;
        if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL refill_pd: got %0d expected %0d", pd_alloc, e.pd); end
        if (fl_empty !== e.empty) begin n_fail++; $display("FAIL refill_empty: got %0b expected %0b", fl_empty, e.empty); end
    endtask

    task automatic test_commit();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        e = sb_q.pop_front();
        n_chk += 3;
        if (rrat[5] !== e.map[30 +: 6]) begin n_fail++; $display("FAIL commit_rrat5: got %0d expected %0d", rrat[5], e.map[30 +: 6]); end
        if (rrat[4] !== e.map[24 +: 6]) begin n_fail++; $display("FAIL commit_rrat4: got %0d expected %0d", rrat[4], e.map[24 +: 6]); end
        if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL commit_pd: got %0d expected %0d", pd_alloc, e.pd); end
        drive(1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        e = sb_q.pop_front();
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if (rrat[i] !== e.map[i*6 +: 6]) begin n_fail++; $display("FAIL x0_rrat[%0d]: got %0d expected %0d", i, rrat[i], e.map[i*6 +: 6]); end
        end
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            e = sb_q.pop_front();
            n_chk += 2;
            if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL commit_drain_pd: got %0d expected %0d", pd_alloc, e.pd); end
            if (fl_empty !== e.empty) begin n_fail++; $display("FAIL commit_drain_empty: got %0b expected %0b", fl_empty, e.empty); end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        void'(sb_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            void'(sb_q.pop_front());
        end
        drive(1'b0, 1'b0, 1'b1, 5'd1, 1'b0);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        e = sb_q.pop_front();
        n_chk += 3;
        if (rrat[1] !== e.map[6 +: 6]) begin n_fail++; $display("FAIL flush_rrat1: got %0d expected %0d", rrat[1], e.map[6 +: 6]); end
        if (pd_alloc !== 6'd33) begin n_fail++; $display("FAIL flush_pd33: got %0d expected 33", pd_alloc); end
        if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL flush_pd: got %0d expected %0d", pd_alloc, e.pd); end
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            e = sb_q.pop_front();
            n_chk += 2;
            if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL flush_seq_pd: got %0d expected %0d", pd_alloc, e.pd); end
            if (fl_empty !== e.empty) begin n_fail++; $display("FAIL flush_seq_empty: got %0b expected %0b", fl_empty, e.empty); end
        end
    endtask

    task automatic test_commit_flush_alloc();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        void'(sb_q.pop_front());
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            void'(sb_q.pop_front());
        end
        drive(1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
        e = sb_q.pop_front();
        n_chk += 2;
        if (rrat[7] !== e.map[42 +: 6]) begin n_fail++; $display("FAIL cfa_rrat7: got %0d expected %0d", rrat[7], e.map[42 +: 6]); end
        if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL cfa_pd: got %0d expected %0d", pd_alloc, e.pd); end
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            e = sb_q.pop_front();
            n_chk += 2;
            if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL cfa_seq_pd: got %0d expected %0d", pd_alloc, e.pd); end
            if (fl_empty !== e.empty) begin n_fail++; $display("FAIL cfa_seq_empty: got %0b expected %0b", fl_empty, e.empty); end
        end
    endtask

    task automatic test_random();
        exp_t       e;
        logic [63:0] seen;
        logic        dup;
        logic        we;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        void'(sb_q.pop_front());
        for (int c = 0; c < 10000; c++) begin
            we = (infl_q.size() > 0) && ($urandom_range(0, 9) < 4);
            drive(1'b0, 1'($urandom_range(0, 1)), we, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 31) == 0));
            e = sb_q.pop_front();
            n_chk += 2;
            if (fl_empty !== e.empty) begin n_fail++; $display("FAIL rand_empty cyc %0d: got %0b expected %0b", c, fl_empty, e.empty); end
            if (pd_alloc !== e.pd) begin n_fail++; $display("FAIL rand_pd cyc %0d: got %0d expected %0d", c, pd_alloc, e.pd); end
            seen = 64'd0;
            dup  = 1'b0;
            for (int i = 0; i < 32; i++) begin
                n_chk++;
                if (rrat[i] !== e.map[i*6 +: 6]) begin n_fail++; $display("FAIL rand_rrat[%0d] cyc %0d: got %0d expected %0d", i, c, rrat[i], e.map[i*6 +: 6]); end
                if (seen[rrat[i]]) dup = 1'b1;
                seen[rrat[i]] = 1'b1;
            end
            n_chk++;
            if (dup !== 1'b0) begin n_fail++; $display("FAIL rand_unique cyc %0d: got duplicate=%0b expected 0", c, dup); end
        end
    endtask

    initial begin
        test_reset();
        test_pop3();
        test_exhaust();
        test_commit();
        test_flush();
        test_commit_flush_alloc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rrat_freelist.md
RRAT_FREELIST -- requirements
Module: rrat_freelist

Interface
REQ-001 SHALL have parameters (name, default, meaning): PHYS_REG_BITS, 6, physical tag width; ARCH_REG_BITS, 5, architectural index width; FL_DEPTH, 32, free-list entries (64 phys - 32 arch).
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-003 alloc_req in 1: dispatch pops one free tag this cycle.
REQ-004 pd_alloc out PHYS_REG_BITS: tag at free-list head, combinational.
REQ-005 fl_empty out 1: no free tag available.
REQ-006 commit_we in 1: ROB head commits an instruction that writes rd.
REQ-007 commit_rd in ARCH_REG_BITS: committing architectural destination.
REQ-008 commit_pd in PHYS_REG_BITS: committing physical destination.
REQ-009 global_branch_signal in 1: mispredict flush, same cycle the RAT restores from rrat.
REQ-010 rrat out PHYS_REG_BITS x32: registered retirement map, consumed by RAT on flush.

Function
REQ-011 Free list SHALL be a circular FIFO: mem[FL_DEPTH], head, tail, count (0..FL_DEPTH).
REQ-012 pd_alloc SHALL equal mem[head]; fl_empty SHALL equal (count==0).
REQ-013 alloc_req with count>0 SHALL advance head by 1 (wrap FL_DEPTH-1->0) at the edge; alloc_req with count==0 SHALL be ignored (no pointer/count change).
REQ-014 Commit with commit_we=1 and commit_rd!=0 SHALL: rrat[commit_rd]<=commit_pd; mem[tail]<=old rrat[commit_rd]; tail+1 (wrap); count+1.
REQ-015 commit_we=0 or commit_rd==0 SHALL change neither rrat nor free list.
REQ-016 Simultaneous valid pop and push SHALL leave count unchanged, both pointers advance; no same-cycle bypass when count==0 (pop ignored, push accepted).
REQ-017 Push with count==FL_DEPTH and no pop is illegal (tag conservation); SHALL be flagged by assertion, never silently dropped.
REQ-018 Flush: head SHALL be set to the post-commit tail value and count to FL_DEPTH; slots holding speculatively allocated tags thereby become free again.
REQ-019 Commit and flush in the same cycle: commit (REQ-014) SHALL apply first; flush uses the incremented tail; rrat includes the commit.
REQ-020 alloc_req coincident with flush SHALL be discarded.
REQ-021 rrat updates SHALL be visible on rrat the cycle after the commit edge; pd_alloc reflects a pop the cycle after the edge.
REQ-022 Invariant: free-list tags, in-flight tags and rrat entries are disjoint, union = all 64 tags.

Reset
REQ-023 On rst: rrat[i]=i for i=0..31; mem[j]=32+j for j=0..31; head=0; tail=0; count=FL_DEPTH.
REQ-024 After reset: pd_alloc=32, fl_empty=0.
REQ-025 rst SHALL override flush, commit and alloc in the same cycle; rst mid-operation discards all state.

Structure
REQ-026 PHYS_REG_BITS, ARCH_REG_BITS, NUM_PHYS_REGS=64 and FL_DEPTH SHALL live in rv32i_types; no new localparams duplicating them.
REQ-027 FIFO storage/pointers SHALL be a sub-module free_list (push, push_data, pop, pop_data, empty, full, flush); rrat array stays in rrat_freelist.
REQ-028 Pointers SHALL be $clog2(FL_DEPTH) bits with explicit wrap; count one bit wider.

Verification
REQ-029 Reset then 3 pops -> pd_alloc 32,33,34 on successive cycles, count 29.
REQ-030 Pop 32 times -> fl_empty=1 after 32nd; further alloc_req -> pd_alloc/count unchanged.
REQ-031 Commit rd=5 pd=32 -> rrat[5]=32 next cycle; tag 5 enqueued at tail; count+1; rd=0 commit -> no change.
REQ-032 Pop 32,33,34; commit rd=1 pd=32; flush -> count=32, pops yield 33,34,...,63,1 in order; rrat[1]=32.
REQ-033 Commit + flush + alloc_req same cycle -> commit applied, alloc discarded, count=32.
REQ-034 Random alloc/commit/flush 10k cycles vs. reference model -> REQ-022 holds every cycle, no overflow assertion.
